sky130_ef_ip__xtal_osc_ctrl: RTL
================================

// Module: sky130_ef_ip__xtal_osc_ctrl
// PURPOSE
//  Synthesizable start-up/supervisor controller for the 32 kHz crystal oscillator macro.
//  Drives the macro's ena/boost pins, synchronises its dout into the clk domain and qualifies it by period.
//  Declares the crystal ready or failed, retries start-up, and emits edge and divided ticks (1 Hz at default DIV).
//  Sits between the always-on digital domain and the analog oscillator.
// PARAMETERS
//  CNT_W       24        width of boost/timeout counter
//  BOOST_CYC   100000    clk cycles boost held high per start-up attempt
//  MIN_PER     250       min legal xtal period, clk cycles (inclusive)
//  MAX_PER     360       max legal xtal period, clk cycles (inclusive)
//  GOOD_EDGES  8         consecutive in-range periods required for ready
//  STARTUP_TMO 10000000  clk cycles allowed in SETTLE before attempt fails
//  RETRIES     2         extra start-up attempts after first failure
//  DIV         32768     qualified edges per div_tick
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      synchronous, active-low reset
//  en         in   1      request oscillator on (level)
//  xtal_dout  in   1      oscillator digital output, asynchronous to clk
//  osc_ena    out  1      to macro ena
//  osc_boost  out  1      to macro boost
//  ready      out  1      crystal qualified, ticks valid
//  fail       out  1      all attempts exhausted / lost lock beyond retries
//  state      out  3      OFF=0 BOOST=1 SETTLE=2 RUN=3 FAIL=4
//  retry_cnt  out  2      failed attempts so far in this enable session (saturating)
//  edge_tick  out  1      1-cycle pulse per qualified xtal rising edge (RUN only)
//  div_tick   out  1      1-cycle pulse every DIV edge_ticks
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): state=OFF; every output 0; all counters, synchroniser, edge history cleared.
//  Sync: 2-flop synchroniser + edge-detect flop; rising edge seen (rise) 3 clk after xtal edge sampled.
//  Period counter per: clears on rise, else increments, saturating at MAX_PER+1.
//  en=0 in any state -> OFF next cycle; retry_cnt and divider cleared; overrides all else in same cycle.
//  OFF: osc_ena=0 osc_boost=0. en=1 -> BOOST.
//  BOOST: osc_ena=1 osc_boost=1; tmr counts BOOST_CYC cycles -> SETTLE; tmr, good count, first-edge flag cleared.
//  SETTLE: osc_ena=1 osc_boost=0; tmr increments.
//   - First rise after entry only arms per; it is not counted.
//   - Later rise: per in [MIN_PER,MAX_PER] -> good++, else good=0.
//   - good reaches GOOD_EDGES -> RUN (ready=1 from next cycle).
//   - tmr reaches STARTUP_TMO first -> attempt failed.
//  RUN: ready=1; rise with legal per -> edge_tick same cycle.
//   - per hits MAX_PER+1 (missing edge) or rise with per<MIN_PER (glitch) -> lost lock = attempt failed; ready drops next cycle.
//  Attempt failed: retry_cnt<RETRIES -> retry_cnt++, BOOST; else FAIL.
//  FAIL: osc_ena=0 osc_boost=0 fail=1; stays until en=0 (then OFF, fail=0).
//  Divider: counts edge_ticks 0..DIV-1; div_tick on edge_tick that wraps DIV-1->0; cleared outside RUN.
//  Simultaneous: timeout and GOOD_EDGES reached in same cycle -> RUN wins.
//  Simultaneous: en falling with any event -> OFF.
//  Outputs registered except edge_tick/div_tick (decoded from registered rise/state/per).
// TESTING (bench params: MIN_PER=8 MAX_PER=12 GOOD_EDGES=4 BOOST_CYC=20 STARTUP_TMO=200 RETRIES=2 DIV=4)
//  1 en=1, xtal period 10 clk -> BOOST 20 cyc (boost=1), SETTLE, RUN after 5th edge; edge_tick each edge; div_tick every 4.
//  2 en=1, xtal stuck low -> 3 attempts (retry_cnt 0,1,2), then FAIL, fail=1 osc_ena=0; en=0 -> OFF, fail=0.
//  3 In RUN, stop xtal -> ready falls 13 cyc after last rise; re-enter BOOST, retry_cnt=1; restart xtal -> RUN.
//  4 SETTLE with periods 10,10,5,10,10,10,10 -> good resets at 5; RUN only after 4 further legal periods.
//  5 en deasserted mid-BOOST and mid-RUN -> OFF next cycle, all outputs 0, retry_cnt=0.
//  6 rst_n=0 mid-RUN for 1 cycle -> all outputs 0 and state=OFF next cycle; with en=1, BOOST follows.

Source files
------------

// File: rtl/sky130_ef_ip__xtal_osc_ctrl_if.sv
// Signal bundle between the crystal supervisor and its host/oscillator side.
// master: drives en and xtal_dout, observes status; slave: the controller.
interface sky130_ef_ip__xtal_osc_ctrl_if;
    logic       en;
    logic       xtal_dout;
    logic       osc_ena;
    logic       osc_boost;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic       edge_tick;
    logic       div_tick;

    modport master (
        output en, xtal_dout,
        input  osc_ena, osc_boost, ready, fail,
        input  state, retry_cnt, edge_tick, div_tick
    );

    modport slave (
        input  en, xtal_dout,
        output osc_ena, osc_boost, ready, fail,
        output state, retry_cnt, edge_tick, div_tick
    );
endinterface

// File: rtl/sky130_ef_ip__xtal_osc_ctrl.sv
// Start-up / supervisor controller for the 32 kHz crystal oscillator macro.
// Ports: clk, rst_n (sync, active-low), bus (slave): en, xtal_dout in;
// osc_ena, osc_boost, ready, fail, state, retry_cnt, edge_tick, div_tick out.
module sky130_ef_ip__xtal_osc_ctrl #(
    parameter int CNT_W       = 24,
    parameter int BOOST_CYC   = 100000,
    parameter int MIN_PER     = 250,
    parameter int MAX_PER     = 360,
    parameter int GOOD_EDGES  = 8,
    parameter int STARTUP_TMO = 10000000,
    parameter int RETRIES     = 2,
    parameter int DIV         = 32768
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sky130_ef_ip__xtal_osc_ctrl_if.slave  bus
);

    localparam int PER_W  = $clog2(MAX_PER + 2);
    localparam int GOOD_W = $clog2(GOOD_EDGES + 1);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int R_SAT  = (RETRIES > 3) ? 3 : RETRIES;

    localparam logic [PER_W-1:0]  P_MIN  = PER_W'(MIN_PER);
    localparam logic [PER_W-1:0]  P_MAX  = PER_W'(MAX_PER);
    localparam logic [PER_W-1:0]  P_SAT  = PER_W'(MAX_PER + 1);
    localparam logic [CNT_W-1:0]  T_BST  = CNT_W'(BOOST_CYC - 1);
    localparam logic [CNT_W-1:0]  T_TMO  = CNT_W'(STARTUP_TMO - 1);
    localparam logic [GOOD_W-1:0] G_LAST = GOOD_W'(GOOD_EDGES - 1);
    localparam logic [1:0]        R_MAX  = 2'(R_SAT);
    localparam logic [DIV_W-1:0]  D_TOP  = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_BOOST  = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t            st, st_n;
    logic              sync1, sync2, sync3, rise;
    logic [PER_W-1:0]  per;
    logic [CNT_W-1:0]  tmr, tmr_n;
    logic [GOOD_W-1:0] good, good_n;
    logic              armed, armed_n;
    logic [1:0]        rcnt, rcnt_n;
    logic [DIV_W-1:0]  dcnt;
    logic              ena_q, boost_q, ready_q, fail_q;
    logic              legal, lost, afail, etick;

    // Synchroniser, edge detect and period measurement. per saturates one
    // past the legal window so a missing edge is a single compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            rise  <= 1'b0;
            per   <= '0;
        end else begin
            sync1 <= bus.xtal_dout;
            sync2 <= sync1;
            sync3 <= sync2;
            rise  <= sync2 & ~sync3;
            if (rise)
                per <= '0;
            else if (per != P_SAT)
                per <= per + 1'b1;
        end
    end

    assign legal = rise && (per >= P_MIN) && (per <= P_MAX);
    assign lost  = (per == P_SAT) || (rise && (per < P_MIN));
    assign etick = (st == S_RUN) && legal;

    always_comb begin
        st_n    = st;
        tmr_n   = tmr;
        good_n  = good;
        armed_n = armed;
        rcnt_n  = rcnt;
        afail   = 1'b0;
        unique case (st)
            S_OFF: begin
                tmr_n   = '0;
                good_n  = '0;
                armed_n = 1'b0;
                if (bus.en)
                    st_n = S_BOOST;
            end
            S_BOOST: begin
                good_n  = '0;
                armed_n = 1'b0;
                if (tmr == T_BST) begin
                    st_n  = S_SETTLE;
                    tmr_n = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            S_SETTLE: begin
                tmr_n = tmr + 1'b1;
                // The first edge only arms the period counter.
                if (rise) begin
                    if (!armed)
                        armed_n = 1'b1;
                    else if (legal)
                        good_n = good + 1'b1;
                    else
                        good_n = '0;
                end
                // Qualification beats a same-cycle timeout.
                if (rise && armed && legal && good == G_LAST)
                    st_n = S_RUN;
                else if (tmr == T_TMO)
                    afail = 1'b1;
            end
            S_RUN: begin
                if (lost)
                    afail = 1'b1;
            end
            S_FAIL: begin
            end
            default: st_n = S_OFF;
        endcase

        if (afail) begin
            tmr_n   = '0;
            good_n  = '0;
            armed_n = 1'b0;
            if (rcnt < R_MAX) begin
                rcnt_n = rcnt + 1'b1;
                st_n   = S_BOOST;
            end else begin
                st_n = S_FAIL;
            end
        end

        // Dropping the request overrides every other event.
        if (!bus.en) begin
            st_n   = S_OFF;
            rcnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st      <= S_OFF;
            tmr     <= '0;
            good    <= '0;
            armed   <= 1'b0;
            rcnt    <= '0;
            dcnt    <= '0;
            ena_q   <= 1'b0;
            boost_q <= 1'b0;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            st      <= st_n;
            tmr     <= tmr_n;
            good    <= good_n;
            armed   <= armed_n;
            rcnt    <= rcnt_n;
            ena_q   <= st_n inside {S_BOOST, S_SETTLE, S_RUN};
            boost_q <= (st_n == S_BOOST);
            ready_q <= (st_n == S_RUN);
            fail_q  <= (st_n == S_FAIL);
            if (st != S_RUN || !bus.en)
                dcnt <= '0;
            else if (etick)
                dcnt <= (dcnt == D_TOP) ? '0 : dcnt + 1'b1;
        end
    end

    assign bus.osc_ena   = ena_q;
    assign bus.osc_boost = boost_q;
    assign bus.ready     = ready_q;
    assign bus.fail      = fail_q;
    assign bus.state     = st;
    assign bus.retry_cnt = rcnt;
    assign bus.edge_tick = etick;
    assign bus.div_tick  = etick && (dcnt == D_TOP);

endmodule
